// File: rtl/spi_cfg_master.sv
// spi_cfg_master: LSB-first SPI frame serialiser (address byte + up to MAX_BYTES data bytes).
// Latency: first bit one iclk after accept; done one iclk after last high phase (plus byte gaps).
// Backpressure: cmd_ready only in IDLE; FETCH stalls with sclk low until byte_valid_i.
// Optional: define SPI_CFG_MASTER_BYTE_GAP_EN to add an 8-cycle quiet gap after every byte.
module spi_cfg_master #(
    parameter int HALF_DIV  = 1,
    parameter int MAX_BYTES = 4,
    localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic             iclk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    input  logic [7:0]       byte_data_i,
    output logic             sclk_o,
    output logic             serial_out_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_GAP   = 3'd2,
        S_FETCH = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int               DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

    state_e             state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;
    logic               sout_q, sout_d;
    logic               sclk_q, busy_q, done_q, byte_rdy_q, cmd_rdy_q;
    logic               sclk_d, busy_d, done_d, byte_rdy_d, cmd_rdy_d;
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
    logic [2:0]         gap_q, gap_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        phase_d   = phase_q;
        sout_d    = sout_q;
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                sout_d = 1'b0;
                if (cmd_valid_i && cmd_rdy_q) begin
                    shreg_d   = cmd_addr_i;
                    rem_d     = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
                    bit_cnt_d = 3'd0;
                    div_d     = '0;
                    phase_d   = 1'b0;
                    sout_d    = cmd_addr_i[0];
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // end of high phase: advance to the next bit of the byte
                        phase_d   = 1'b0;
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
                            gap_d   = 3'd0;
                            sout_d  = 1'b0;
                            state_d = S_GAP;
`else
                            if (rem_q != '0) begin
                                state_d = S_FETCH;
                            end else begin
                                sout_d  = 1'b0;
                                state_d = S_DONE;
                            end
`endif
                        end else begin
                            sout_d = shreg_q[1];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
                gap_d = gap_q + 3'd1;
                if (gap_q == 3'd7) begin
                    state_d = (rem_q != '0) ? S_FETCH : S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_FETCH: begin
                if (byte_valid_i) begin
                    shreg_d   = byte_data_i;
                    rem_d     = rem_q - LEN_W'(1);
                    bit_cnt_d = 3'd0;
                    div_d     = '0;
                    phase_d   = 1'b0;
                    sout_d    = byte_data_i[0];
                    state_d   = S_SHIFT;
                end
            end
            S_DONE: begin
                sout_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                sout_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free and cycle-aligned.
    assign sclk_d     = (state_d == S_SHIFT) && phase_d;
    assign busy_d     = (state_d == S_SHIFT) || (state_d == S_GAP) || (state_d == S_FETCH);
    assign done_d     = (state_d == S_DONE);
    assign byte_rdy_d = (state_d == S_FETCH);
    assign cmd_rdy_d  = (state_d == S_IDLE);

    always_ff @(posedge iclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            shreg_q    <= 8'd0;
            rem_q      <= '0;
            bit_cnt_q  <= 3'd0;
            div_q      <= '0;
            phase_q    <= 1'b0;
            sout_q     <= 1'b0;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_rdy_q <= 1'b0;
            cmd_rdy_q  <= 1'b0;
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
            gap_q      <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rem_q      <= rem_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            sout_q     <= sout_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_rdy_q <= byte_rdy_d;
            cmd_rdy_q  <= cmd_rdy_d;
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign cmd_ready_o  = cmd_rdy_q;
    assign byte_ready_o = byte_rdy_q;
    assign sclk_o       = sclk_q;
    assign serial_out_o = sout_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: randomized frames checked against a bit-list / cycle-count model.
module tb_spi_cfg_master;
    localparam int HD = 3;
    localparam int MB = 4;
    localparam int LW = $clog2(MB + 1);
`ifdef SPI_CFG_MASTER_BYTE_GAP_EN
    localparam int GAP = 8;
`else
    localparam int GAP = 0;
`endif

    logic          iclk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready;
    logic [7:0]    cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          byte_valid, byte_ready;
    logic [7:0]    byte_data;
    logic          sclk, serial_out, busy, done;

    spi_cfg_master #(.HALF_DIV(HD), .MAX_BYTES(MB)) u_dut (
        .iclk_i(iclk), .rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .byte_valid_i(byte_valid), .byte_ready_o(byte_ready), .byte_data_i(byte_data),
        .sclk_o(sclk), .serial_out_o(serial_out), .busy_o(busy), .done_o(done)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic       obs_bits[$];
    logic       exp_bits[$];
    logic [7:0] tx_data[MB+4];
    int         tx_stall[MB+4];
    int rises, done_cnt, busy_cyc, br_seen, viol_fetch, viol_hi, viol_per, done_viol;
    int acc_cyc, done_cyc, last_hi_cyc;
    logic [5:0] ab_vec;

    function automatic int clamp_len(input int l);
        return (l > MB) ? MB : l;
    endfunction

    // Reference: the frame is just the address then n data bytes, each LSB first.
    function automatic void build_exp(input logic [7:0] a, input int n);
        exp_bits.delete();
        for (int i = 0; i < 8; i++) exp_bits.push_back(a[i]);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) exp_bits.push_back(tx_data[k][i]);
    endfunction

    function automatic int exp_busy(input int n);
        int s;
        s = (n + 1) * (16 * HD + GAP);
        for (int k = 0; k < n; k++) s += tx_stall[k] + 1;
        return s;
    endfunction

    function automatic int bits_diff();
        int d;
        d = (obs_bits.size() > exp_bits.size()) ? obs_bits.size() - exp_bits.size()
                                                : exp_bits.size() - obs_bits.size();
        for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++)
            if (obs_bits[i] !== exp_bits[i]) d++;
        return d;
    endfunction

    // Drives one command and observes the wire until done (or abort); called at a negedge.
    task automatic run_frame(input logic [7:0] a, input logic [LW-1:0] l, input bit hold,
                             input logic [7:0] na, input logic [LW-1:0] nl, input int abort_at);
        int t, bi, wc, hi_run, last_rise;
        logic psclk;
        obs_bits.delete();
        rises = 0; done_cnt = 0; busy_cyc = 0; br_seen = 0; viol_fetch = 0;
        viol_hi = 0; viol_per = 0; done_viol = 0; last_hi_cyc = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge iclk);
            t++;
        end
        if (t >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        bi = 0; wc = 0; hi_run = 0; psclk = 1'b0; last_rise = 0;
        t = 0;
        while (t < 5000) begin
            @(negedge iclk);
            t++;
            if (t == 1) begin
                if (hold) begin
                    cmd_addr = na;
                    cmd_len  = nl;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (busy === 1'b1) busy_cyc++;
            if (sclk === 1'b1 && psclk !== 1'b1) begin
                if (rises % 8 != 0 && cyc - last_rise != 2 * HD) viol_per++;
                last_rise = cyc;
                obs_bits.push_back(serial_out);
                rises++;
            end
            if (sclk === 1'b1) begin
                hi_run++;
                last_hi_cyc = cyc;
            end else begin
                if (psclk === 1'b1 && hi_run != HD) viol_hi++;
                hi_run = 0;
            end
            psclk = sclk;
            if (abort_at > 0 && rises == abort_at) begin
                rstn = 1'b0;
                #1;
                ab_vec = {sclk, serial_out, busy, done, byte_ready, cmd_ready};
                byte_valid = 1'b0;
                cmd_valid  = 1'b0;
                return;
            end
            if (byte_ready === 1'b1) begin
                br_seen++;
                if (sclk !== 1'b0) viol_fetch++;
                if (bi < MB + 4 && wc < tx_stall[bi]) begin
                    byte_valid = 1'b0;
                    byte_data  = 8'($urandom);
                    wc++;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = (bi < MB + 4) ? tx_data[bi] : 8'h00;
                    bi++;
                    wc = 0;
                end
            end else begin
                byte_valid = 1'($urandom);
                byte_data  = 8'($urandom);
                wc = 0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy !== 1'b0 || sclk !== 1'b0 || serial_out !== 1'b0) done_viol++;
                byte_valid = 1'b0;
                return;
            end
        end
        n_checks++; n_fail++;
        $display("FAIL frame_timeout: no done after %0d cycles, required done", t);
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_len = '0;
        byte_valid = 1'b0; byte_data = 8'h00;
        #22;
        n_checks++;
        if ({sclk, serial_out, busy, done, byte_ready, cmd_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {sclk, serial_out, busy, done, byte_ready, cmd_ready});
        end
        @(negedge iclk);
        rstn = 1'b1;
        @(negedge iclk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        tx_data[0] = 8'hAA; tx_stall[0] = 0;
        run_frame(8'h01, LW'(1), 1'b0, 8'h00, '0, 0);
        build_exp(8'h01, 1);
        n_checks++;
        if (bits_diff() !== 0) begin
            n_fail++;
            $display("FAIL basic_bits: %0d differing bits, required 0", bits_diff());
        end
        n_checks++;
        if (rises !== 16) begin
            n_fail++;
            $display("FAIL basic_rises: got %0d, required 16", rises);
        end
        n_checks++;
        if (done_cyc - last_hi_cyc !== 1 + GAP) begin
            n_fail++;
            $display("FAIL basic_done_timing: %0d cycles after last high, required %0d",
                     done_cyc - last_hi_cyc, 1 + GAP);
        end
        n_checks++;
        if (viol_hi + viol_per + done_viol !== 0) begin
            n_fail++;
            $display("FAIL basic_shape: hi=%0d per=%0d done=%0d violations, required 0",
                     viol_hi, viol_per, done_viol);
        end
        @(negedge iclk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done,busy=%b one cycle later, required 00", {done, busy});
        end
    endtask

    task automatic test_addr_only();
        run_frame(8'h03, '0, 1'b0, 8'h00, '0, 0);
        build_exp(8'h03, 0);
        n_checks++;
        if (rises !== 8 || bits_diff() !== 0) begin
            n_fail++;
            $display("FAIL addr_only_frame: rises=%0d diff=%0d, required 8 and 0", rises, bits_diff());
        end
        n_checks++;
        if (br_seen !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL addr_only_handshake: byte_ready cycles=%0d done=%0d, required 0 and 1",
                     br_seen, done_cnt);
        end
    endtask

    task automatic test_stall();
        tx_data[0] = 8'h3C; tx_stall[0] = 20;
        tx_data[1] = 8'hC5; tx_stall[1] = 0;
        @(negedge iclk);
        run_frame(8'h81, LW'(2), 1'b0, 8'h00, '0, 0);
        build_exp(8'h81, 2);
        n_checks++;
        if (rises !== 24 || bits_diff() !== 0) begin
            n_fail++;
            $display("FAIL stall_frame: rises=%0d diff=%0d, required 24 and 0", rises, bits_diff());
        end
        n_checks++;
        if (viol_fetch !== 0 || br_seen !== 22) begin
            n_fail++;
            $display("FAIL stall_fetch: sclk-high=%0d fetch cycles=%0d, required 0 and 22",
                     viol_fetch, br_seen);
        end
        n_checks++;
        if (busy_cyc !== exp_busy(2)) begin
            n_fail++;
            $display("FAIL stall_busy: got %0d cycles, required %0d", busy_cyc, exp_busy(2));
        end
    endtask

    task automatic test_clamp();
        for (int k = 0; k < MB; k++) begin
            tx_data[k]  = 8'($urandom);
            tx_stall[k] = 0;
        end
        @(negedge iclk);
        run_frame(8'h5E, LW'(7), 1'b0, 8'h00, '0, 0);
        build_exp(8'h5E, MB);
        n_checks++;
        if (rises !== 8 * (MB + 1) || bits_diff() !== 0) begin
            n_fail++;
            $display("FAIL clamp_frame: rises=%0d diff=%0d, required %0d and 0",
                     rises, bits_diff(), 8 * (MB + 1));
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        int l, n;
        for (int f = 0; f < 10; f++) begin
            a = 8'($urandom);
            l = $urandom_range(0, (1 << LW) - 1);
            n = clamp_len(l);
            for (int k = 0; k < MB; k++) begin
                tx_data[k]  = 8'($urandom);
                tx_stall[k] = $urandom_range(0, 3);
            end
            repeat ($urandom_range(0, 2)) @(negedge iclk);
            run_frame(a, LW'(l), 1'b0, 8'h00, '0, 0);
            build_exp(a, n);
            n_checks++;
            if (bits_diff() !== 0 || rises !== 8 * (n + 1)) begin
                n_fail++;
                $display("FAIL random_frame[%0d]: diff=%0d rises=%0d, required 0 and %0d",
                         f, bits_diff(), rises, 8 * (n + 1));
            end
            n_checks++;
            if (busy_cyc !== exp_busy(n) || done_cnt !== 1) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: busy=%0d done=%0d, required %0d and 1",
                         f, busy_cyc, done_cnt, exp_busy(n));
            end
            n_checks++;
            if (viol_hi + viol_per + viol_fetch + done_viol !== 0) begin
                n_fail++;
                $display("FAIL random_shape[%0d]: %0d waveform violations, required 0",
                         f, viol_hi + viol_per + viol_fetch + done_viol);
            end
        end
    endtask

    task automatic test_reset_abort();
        tx_data[0] = 8'hFF; tx_stall[0] = 1;
        tx_data[1] = 8'h0F; tx_stall[1] = 0;
        @(negedge iclk);
        run_frame(8'hA5, LW'(2), 1'b0, 8'h00, '0, 13);
        n_checks++;
        if (ab_vec !== 6'b0 || done_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b done=%0d, required 000000 and 0", ab_vec, done_cnt);
        end
        repeat (3) @(negedge iclk);
        rstn = 1'b1;
        @(negedge iclk);
        tx_data[0] = 8'h96; tx_stall[0] = 0;
        run_frame(8'h42, LW'(1), 1'b0, 8'h00, '0, 0);
        build_exp(8'h42, 1);
        n_checks++;
        if (bits_diff() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL abort_recover: diff=%0d done=%0d, required 0 and 1", bits_diff(), done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        tx_data[0] = 8'h5A; tx_stall[0] = 0;
        @(negedge iclk);
        run_frame(8'h02, LW'(1), 1'b1, 8'h01, LW'(1), 0);
        build_exp(8'h02, 1);
        d1 = done_cyc;
        n_checks++;
        if (bits_diff() !== 0) begin
            n_fail++;
            $display("FAIL b2b_first: %0d differing bits, required 0", bits_diff());
        end
        tx_data[0] = 8'hF0; tx_stall[0] = 0;
        run_frame(8'h01, LW'(1), 1'b0, 8'h00, '0, 0);
        build_exp(8'h01, 1);
        n_checks++;
        if (acc_cyc - d1 !== 1) begin
            n_fail++;
            $display("FAIL b2b_accept_gap: %0d cycles after done, required 1", acc_cyc - d1);
        end
        n_checks++;
        if (bits_diff() !== 0 || viol_per !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: diff=%0d period violations=%0d, required 0 and 0",
                     bits_diff(), viol_per);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_only();
        test_stall();
        test_clamp();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete, required completion");
        $fatal(1);
    end

endmodule
